// File: rtl/fsm_pkg.sv
// Shared encodings and helpers for the w stream transmitter
// and its lockstep model of the six-state sequence detector.
package fsm_pkg;

    localparam logic [2:0] A = 3'd0;
    localparam logic [2:0] B = 3'd1;
    localparam logic [2:0] C = 3'd2;
    localparam logic [2:0] D = 3'd3;
    localparam logic [2:0] E = 3'd4;
    localparam logic [2:0] F = 3'd5;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    function automatic logic [2:0] det_next(
        input logic [2:0] state,
        input logic       w
    );
        logic [2:0] n;
        n = A;
        case (state)
            A:       n = w ? A : B;
            B:       n = w ? D : C;
            C:       n = w ? D : E;
            D:       n = w ? A : F;
            E:       n = w ? D : E;
            F:       n = w ? D : C;
            default: n = A;
        endcase
        return n;
    endfunction

    function automatic logic det_z(input logic [2:0] state);
        return (state == E) || (state == F);
    endfunction

endpackage

// File: rtl/w_stream_tx_det_model.sv
// Reference model of the sequence detector: state register
// advanced on consumed bits, with a synchronous clear.
module det_model
    import fsm_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_clear,
    input  logic       i_en,
    input  logic       i_w,
    output logic [2:0] o_state,
    output logic       o_z
);

    logic [2:0] r_state;

    // Clear wins over a consumed bit; otherwise step on consume.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= A;
        end else if (i_clear) begin
            r_state <= A;
        end else if (i_en) begin
            r_state <= det_next(r_state, i_w);
        end
    end

    assign o_state = r_state;
    assign o_z     = det_z(r_state);

endmodule

// File: rtl/w_stream_tx.sv
// Parallel-in, MSB-first serial transmitter feeding the detector,
// with a lockstep detector model and per-frame hit counter.
module w_stream_tx
    import fsm_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             bit_en,
    input  logic             clear_model,
    output logic             w,
    output logic             w_valid,
    output logic [2:0]       exp_state,
    output logic             exp_z,
    output logic [CW-1:0]    hit_count,
    output logic             done
);

    localparam logic [CW-1:0] W_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] W_ONE  = CW'(1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_bitcnt;
    logic [CW-1:0]    r_hits;
    logic             r_ready;
    logic             r_wvalid;
    logic             r_done;

    logic             w_consume;
    logic             w_hit;

    assign w_consume = (r_state == S_SHIFT) && bit_en;
    // A cleared bit sends the model to A, which is never a hit.
    assign w_hit     = !clear_model && det_z(det_next(exp_state, w));

    det_model u_model (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clear (clear_model),
        .i_en    (w_consume),
        .i_w     (w),
        .o_state (exp_state),
        .o_z     (exp_z)
    );

    // Control FSM, shift register, bit and hit counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_shreg  <= '0;
            r_bitcnt <= '0;
            r_hits   <= '0;
            r_ready  <= 1'b1;
            r_wvalid <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (load_valid) begin
                        r_shreg  <= load_data;
                        r_bitcnt <= W_FULL;
                        r_hits   <= '0;
                        r_ready  <= 1'b0;
                        r_wvalid <= 1'b1;
                        r_state  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (bit_en) begin
                        r_shreg  <= {r_shreg[WIDTH-2:0], 1'b0};
                        r_bitcnt <= r_bitcnt - W_ONE;
                        if (w_hit && r_hits != W_FULL) begin
                            r_hits <= r_hits + W_ONE;
                        end
                        if (r_bitcnt == W_ONE) begin
                            r_wvalid <= 1'b0;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ready  <= 1'b1;
                    r_wvalid <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign w          = r_shreg[WIDTH-1];
    assign w_valid    = r_wvalid;
    assign load_ready = r_ready;
    assign hit_count  = r_hits;
    assign done       = r_done;

endmodule

// File: tb/tb_w_stream_tx.sv
// Randomized bench for w_stream_tx against a table-driven
// detector model and frame timing reference.
module tb_w_stream_tx;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       load_valid;
    logic       load_ready;
    logic [7:0] load_data;
    logic       bit_en;
    logic       clear_model;
    logic       w;
    logic       w_valid;
    logic [2:0] exp_state;
    logic       exp_z;
    logic [3:0] hit_count;
    logic       done;

    int n_checks = 0;
    int n_errs   = 0;
    int m_state  = 0;

    // Detector transitions, indexed by current state.
    int nxt0 [6] = '{1, 2, 4, 5, 4, 2};
    int nxt1 [6] = '{0, 3, 3, 0, 3, 3};

    always #5 clk = ~clk;

    w_stream_tx #(.WIDTH(8)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .bit_en      (bit_en),
        .clear_model (clear_model),
        .w           (w),
        .w_valid     (w_valid),
        .exp_state   (exp_state),
        .exp_z       (exp_z),
        .hit_count   (hit_count),
        .done        (done)
    );

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".ready"}, 32'(load_ready), 1);
        check({tag, ".w"}, 32'(w), 0);
        check({tag, ".wvalid"}, 32'(w_valid), 0);
        check({tag, ".state"}, 32'(exp_state), 0);
        check({tag, ".z"}, 32'(exp_z), 0);
        check({tag, ".hits"}, 32'(hit_count), 0);
        check({tag, ".done"}, 32'(done), 0);
    endtask

    // Clear the model while idle; caller sits on a negedge.
    task automatic clear_idle();
        clear_model = 1'b1;
        @(negedge clk);
        clear_model = 1'b0;
        m_state = 0;
        check("clr_idle.state", 32'(exp_state), 0);
    endtask

    // One frame. pat: 0 bit_en=1, 1 toggle 1/0, 2 random.
    // clr_at: consumed-bit index (1-based) carrying clear, 0 none.
    task automatic run_frame(
        input logic [7:0] d,
        input int         pat,
        input int         clr_at,
        input bit         keep,
        input int         exp_hits,
        input int         exp_done
    );
        int  idx, cyc, used, hits, k;
        bit  en, clr;
        idx = 7; cyc = 0; used = 0; hits = 0; k = 0;
        while (!load_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("idle.ready", 32'(load_ready), 1);
        load_valid  = 1'b1;
        load_data   = d;
        bit_en      = 1'($urandom);
        clear_model = 1'b0;
        while (idx >= 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                load_data = 8'($urandom);
                if (!keep) load_valid = 1'b0;
            end
            check("sh.wvalid", 32'(w_valid), 1);
            check("sh.w", 32'(w), 32'(d[idx]));
            check("sh.state", 32'(exp_state), 32'(m_state));
            check("sh.z", 32'(exp_z), 32'(m_state >= 4));
            check("sh.ready", 32'(load_ready), 0);
            check("sh.done", 32'(done), 0);
            case (pat)
                0:       en = 1'b1;
                1:       en = (cyc % 2) == 1;
                default: en = $urandom_range(0, 3) != 0;
            endcase
            clr = en && (used + 1 == clr_at);
            bit_en      = en;
            clear_model = clr;
            if (en) begin
                m_state = clr ? 0 : (d[idx] ? nxt1[m_state]
                                            : nxt0[m_state]);
                if (!clr && m_state >= 4) hits++;
                idx--;
                used++;
            end
        end
        check("sh.bound", 32'(idx < 0), 1);
        @(negedge clk);
        cyc++;
        bit_en      = 1'($urandom);
        clear_model = 1'b0;
        check("dn.done", 32'(done), 1);
        check("dn.hits", 32'(hit_count), 32'(hits));
        check("dn.state", 32'(exp_state), 32'(m_state));
        check("dn.wvalid", 32'(w_valid), 0);
        check("dn.ready", 32'(load_ready), 0);
        if (exp_hits >= 0) check("dn.spec_hits", 32'(hit_count), 32'(exp_hits));
        if (exp_done > 0) check("dn.cycle", 32'(cyc), 32'(exp_done));
        @(negedge clk);
        check("post.ready", 32'(load_ready), 1);
        check("post.done", 32'(done), 0);
        check("post.state", 32'(exp_state), 32'(m_state));
    endtask

    initial begin
        reset_n     = 1'b0;
        load_valid  = 1'b0;
        load_data   = '0;
        bit_en      = 1'b0;
        clear_model = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        reset_n = 1'b1;
        @(negedge clk);
        check_reset_vals("rst_rel");

        run_frame(8'h00, 0, 0, 1'b0, 6, 9);
        check("f00.state", 32'(exp_state), 4);
        clear_idle();
        run_frame(8'hFF, 0, 0, 1'b0, 0, 9);
        clear_idle();
        run_frame(8'b0100_1001, 0, 0, 1'b0, 2, 9);
        check("f49.state", 32'(exp_state), 3);
        clear_idle();
        run_frame(8'b0100_1001, 1, 0, 1'b0, 2, 16);
        clear_idle();
        run_frame(8'h00, 0, 3, 1'b0, -1, 9);

        for (int i = 0; i < 12; i++) begin
            run_frame(8'($urandom), 2, $urandom_range(0, 8),
                      1'b0, -1, 0);
        end

        run_frame(8'($urandom), 0, 0, 1'b1, -1, 9);
        run_frame(8'($urandom), 2, 0, 1'b1, -1, 0);

        // Busy with load_valid held; reset in 4th SHIFT cycle.
        load_valid = 1'b1;
        load_data  = 8'hA5;
        bit_en     = 1'b1;
        for (int i = 0; i < 4; i++) @(negedge clk);
        check("ab.wvalid", 32'(w_valid), 1);
        #2 reset_n = 1'b0;
        #1 check_reset_vals("abort");
        load_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort.hold_done", 32'(done), 0);
        end
        reset_n = 1'b1;
        m_state = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort.no_done", 32'(done), 0);
            check("abort.ready", 32'(load_ready), 1);
        end
        run_frame(8'h00, 0, 0, 1'b0, 6, 9);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
